// File: rtl/ct_f_spsram_512x44_ctrl.sv
// ct_f_spsram_512x44_ctrl
// Access controller for the 512x44 single-port SRAM wrapper. Zero-fills the
// array after reset (when CT_SPSRAM_CTRL_INIT_EN is defined), converts a
// valid/ready request stream into SRAM cycles, expands 2-bit half-word write
// masks into active-low bit-write enables, and returns read data through a
// credit-limited response FIFO so the consumer may apply backpressure.
//
// Optional feature macro: CT_SPSRAM_CTRL_INIT_EN (zero-fill after reset).
// With the macro undefined there is no INIT state and init_done rises on the
// first clock after reset release.

module ct_f_spsram_512x44_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 44,
    parameter int WRAP_SIZE   = 22,
    parameter int RSP_CREDITS = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    localparam int CNT_W = $clog2(RSP_CREDITS + 1);
    localparam int PTR_W = (RSP_CREDITS > 1) ? $clog2(RSP_CREDITS) : 1;

    logic                  init_active;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  push;
    logic                  pop;
    logic                  rd_pend;
    logic [CNT_W-1:0]      credit_cnt;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_CREDITS];
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_CREDITS - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef CT_SPSRAM_CTRL_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_done_next;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_INIT;
        else     state <= state_next;
    end

    // Init address counter and registered completion flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            if (init_active) init_cnt <= init_cnt + 1'b1;
            init_done <= init_done_next;
        end
    end

    // Next-state logic: sweep all addresses once, then stay in RUN.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        init_done_next = init_done;
        init_active    = 1'b0;
        case (state)
            S_INIT: begin
                // Gated by RST so the pins show idle values while reset is held.
                init_active = ~RST;
                if (init_cnt == LAST_ADDR) begin
                    state_next     = S_RUN;
                    init_done_next = 1'b1;
                end
            end
            S_RUN: begin
                state_next = S_RUN;
            end
        endcase
    end
`else
    // Without zero-fill the controller is ready on the first clock after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) init_done <= 1'b0;
        else     init_done <= 1'b1;
    end

    assign init_active = 1'b0;
`endif

    // Request handshake: a request is only taken when a response slot is free.
    assign req_rdy   = init_done & (credit_cnt < CNT_W'(RSP_CREDITS));
    assign rd_accept = req_vld & req_rdy & ~req_wr;
    assign wr_accept = req_vld & req_rdy & req_wr;

    // Response side: head of the FIFO, forced to zero when empty.
    assign push      = rd_pend;
    assign pop       = rsp_vld & rsp_rdy;
    assign rsp_vld   = (fifo_cnt != '0);
    assign rsp_rdata = rsp_vld ? fifo_mem[rd_ptr] : '0;

    // SRAM pin drive: init sweep, accepted read, accepted masked write, or idle.
    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        A    = a_q;
        D    = d_q;
        if (init_active) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
            A    = init_cnt;
`endif
            D    = '0;
        end else if (rd_accept) begin
            CEN  = 1'b0;
            A    = req_addr;
        end else if (wr_accept && (req_wmask != 2'b00)) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            A    = req_addr;
            D    = req_wdata;
            WEN  = {{WRAP_SIZE{~req_wmask[1]}}, {WRAP_SIZE{~req_wmask[0]}}};
        end
    end

    // Hold the last driven address/data so idle cycles do not toggle the pins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= A;
            d_q <= D;
        end
    end

    // Outstanding-read credits and the one-cycle read-in-flight marker.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            credit_cnt <= '0;
            rd_pend    <= 1'b0;
        end else begin
            rd_pend <= rd_accept;
            case ({rd_accept, pop})
                2'b10:   credit_cnt <= credit_cnt + 1'b1;
                2'b01:   credit_cnt <= credit_cnt - 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Response FIFO storage: captures Q the cycle after each accepted read.
    // NOTE: storage has no reset; validity comes from fifo_cnt and the head is
    // masked to zero when empty, so the array can map to plain flops or RAM.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= Q;
    end

    // Credits bound the FIFO; an overflow would mean the credit logic is broken.
    fifo_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(push && !pop && (fifo_cnt == CNT_W'(RSP_CREDITS))));

endmodule

// File: doc/ct_f_spsram_512x44_ctrl.md
# ct_f_spsram_512x44_ctrl

Access controller that sits directly upstream of the 512x44 single-port SRAM wrapper and owns its `A/CEN/GWEN/WEN/D/Q` pins. It zero-fills the array after reset, turns a valid/ready request stream into SRAM cycles, and maps 2-bit half-word write masks onto the active-low bit-write enables. Read data passes through a credit-limited 3-entry response FIFO, so the consumer can apply backpressure without losing data.

## Interface
Parameters:
- `ADDR_WIDTH`, 9: SRAM address width.
- `DATA_WIDTH`, 44: SRAM data width.
- `WRAP_SIZE`, 22: half-word width; `DATA_WIDTH = 2*WRAP_SIZE`.
- `RSP_CREDITS`, 3: response FIFO depth, which is also the maximum number of outstanding reads.

Ports:
- `CLK`  in  1: single clock; all state is on the rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `req_vld`  in  1: request valid.
- `req_rdy`  out  1: request ready; a request is accepted on a cycle where `req_vld & req_rdy`.
- `req_wr`  in  1: 1 = write, 0 = read.
- `req_addr`  in  `ADDR_WIDTH`: word address.
- `req_wdata`  in  `DATA_WIDTH`: write data.
- `req_wmask`  in  2: bit0 enables `[21:0]`, bit1 enables `[43:22]`; active-high.
- `rsp_vld`  out  1: read response valid (FIFO head present).
- `rsp_rdy`  in  1: consumer ready for the response.
- `rsp_rdata`  out  `DATA_WIDTH`: read data at the FIFO head.
- `init_done`  out  1: zero-fill complete.
- `A`  out  `ADDR_WIDTH`: SRAM address.
- `CEN`  out  1: SRAM chip enable, active-low.
- `GWEN`  out  1: SRAM global write enable, active-low.
- `WEN`  out  `DATA_WIDTH`: SRAM bit-write enables, active-low.
- `D`  out  `DATA_WIDTH`: SRAM write data.
- `Q`  in  `DATA_WIDTH`: SRAM read data, valid the cycle after the read.

## Operation
States:
- **INIT**: entered on reset.
  - An init counter runs 0..511. Each cycle drives `CEN=0`, `GWEN=0`, `WEN=0`, `D=0`, `A=counter`.
  - After the write at address 511, the FSM moves to **RUN**.
- **RUN**: no exit other than reset.
  - `req_rdy = init_done & (credit_cnt < RSP_CREDITS)`. Writes are gated the same way, so `req_rdy` does not depend on `req_wr`.
  - **Accepted read:** SRAM pins are driven combinationally from the request in the same cycle: `CEN=0`, `GWEN=1`, `A=req_addr`. `credit_cnt` increments. One cycle later, `Q` is pushed into the FIFO.
  - **Accepted write, mask != 0:** `CEN=0`, `GWEN=0`, `A=req_addr`, `D=req_wdata`. `WEN[21:0]` = all `~mask[0]`; `WEN[43:22]` = all `~mask[1]`. Credits are not affected.
  - **Accepted write, mask == 0:** handshake completes, but `CEN` stays 1 (no SRAM access).
  - **No accepted request:** `CEN=1`, `GWEN=1`, `WEN` all 1. `A` and `D` hold their last driven values.
- **Credits:**
  - `credit_cnt` = reads in flight (0/1) + FIFO occupancy.
  - It decrements on `rsp_vld & rsp_rdy`.
  - A read accept and a pop in the same cycle leave the count unchanged.
  - By construction the FIFO never overflows; an overflow is an assertion failure.
- **Ordering:** responses leave in request order. A write followed by a read to the same address on the next cycle returns the new data.
- **Reset values:**
  - Request/response side: `req_rdy=0`, `rsp_vld=0`, `rsp_rdata=0`, `init_done=0`.
  - SRAM side while `RST` is high: `CEN=1`, `GWEN=1`, `WEN` all 1, `A=0`, `D=0`.
  - Internal: FIFO empty, `credit_cnt=0`, init counter 0.
- **Reset mid-operation:** the in-flight read is dropped, the FIFO is flushed, and INIT restarts at address 0.

## Timing
- **INIT duration:** 512 cycles after `RST` deasserts. The first init write (address 0) is in the first cycle after release.
  - `init_done` is registered and rises in cycle 513 after release.
  - `req_rdy` can first be 1 in that same cycle.
- **Read latency:** accept in cycle N, `Q` sampled at the end of N+1, `rsp_vld` high at the earliest in N+2.
- **Throughput:** with `rsp_rdy` held at 1, one request per cycle is sustained indefinitely.
- **Backpressure:** with `rsp_rdy=0`, at most 3 reads are accepted. `req_rdy` drops in the cycle after the third accept.
- **Stable response:** `rsp_rdata` and `rsp_vld` stay stable while `rsp_vld & ~rsp_rdy`.

## Configuration
- Macro: `CT_SPSRAM_CTRL_INIT_EN`.
- **Defined:** INIT zero-fill runs as described above.
- **Undefined:**
  - No INIT state and no init counter.
  - `init_done` goes to 1 in the first cycle after `RST` deasserts.
  - The SRAM is not written until the first write request; array contents are undefined until written.

## Test plan
- **Zero-fill:** release `RST` -> 512 consecutive cycles with `CEN=0`, `GWEN=0`, `A` = 0..511, `D=0`; `init_done=1` at cycle 513. Then read address 511 -> `rsp_rdata = 0`, with `rsp_vld` 2 cycles after accept.
- **Full write/read:** write 0x1A5 with data 0xABCDEF01234, mask 2'b11; then read 0x1A5 -> `rsp_rdata = 0xABCDEF01234`.
- **Half mask:** after init, write 0x010 with 0xFFFFFFFFFFF, mask 2'b01 -> `WEN[21:0]=0`, `WEN[43:22]` all 1. Read 0x010 -> 0x000003FFFFF.
- **Backpressure:** `rsp_rdy=0`, present 5 back-to-back reads to 0..4 -> exactly 3 accepted and `req_rdy=0`. Then set `rsp_rdy=1` -> responses for addresses 0, 1, 2 arrive in order, and the remaining 2 reads are then accepted.
- **Reset mid-init:** assert `RST` while the init counter is at 100 -> all outputs return to reset values. After release, INIT restarts at `A=0` and `init_done` rises 513 cycles after release.
- **Streaming:** `rsp_rdy=1`, 16 back-to-back reads -> `req_rdy` never drops and 16 consecutive `rsp_vld` cycles start 2 cycles after the first accept.
